// File: rtl/muldiv_seq.sv
// Sequencer for the multi-cycle multiply/divide unit: launches mult or div,
// times the fixed latency, then commits HI/LO in one cycle (Moore outputs).
module muldiv_seq #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic op_div,
    input  logic b_is_zero,
    input  logic abort,
    output logic init_mult,
    output logic init_div,
    output logic hilo_sel,
    output logic hi_write,
    output logic lo_write,
    output logic busy,
    output logic done,
    output logic div0_exc,
    output logic cause_write
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_WRITE,
        S_EXC
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    // Holds ~op_q directly, so reset gives hilo_sel = 0 and the op is recovered by inversion.
    logic             r_hilo_sel;
    logic             w_hilo_sel_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hilo_sel <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hilo_sel <= w_hilo_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hilo_sel_nxt = r_hilo_sel;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (op_div && b_is_zero) begin
                        w_state_nxt = S_EXC;
                    end else begin
                        w_state_nxt    = S_LAUNCH;
                        w_hilo_sel_nxt = ~op_div;
                    end
                end
            end
            S_LAUNCH: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_hilo_sel ? MULT_LOAD : DIV_LOAD;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_WRITE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_WRITE:  w_state_nxt = S_IDLE;
            S_EXC:    w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        init_mult   = (r_state == S_LAUNCH) &&  r_hilo_sel;
        init_div    = (r_state == S_LAUNCH) && !r_hilo_sel;
        hilo_sel    = r_hilo_sel;
        busy        = (r_state != S_IDLE);
        hi_write    = (r_state == S_WRITE);
        lo_write    = (r_state == S_WRITE);
        done        = (r_state == S_WRITE);
        div0_exc    = (r_state == S_EXC);
        cause_write = (r_state == S_EXC);
    end

endmodule
